// File: rtl/dmul_share_arbiter_pkg.sv
// dmul_share_arbiter_pkg: shared tag type and limits for the multiplier share arbiter
package dmul_share_arbiter_pkg;
    localparam int DMUL_REQ_MAX = 8;
    localparam int REQ_ID_W     = $clog2(DMUL_REQ_MAX);
    localparam int CNT_W        = 4;

    typedef struct packed {
        logic [REQ_ID_W-1:0] req_id;
    } tag_t;
endpackage

// File: rtl/dmul_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first eligible at or after ptr wins
//   elig  : eligibility vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot grant, idx : its index, found : a grant exists
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // Walk from farthest to nearest so the nearest eligible overwrites the rest.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (elig[W'(j)]) begin
                grant        = '0;
                grant[W'(j)] = 1'b1;
                idx          = W'(j);
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmul_share_arbiter.sv
// dmul_share_arbiter: round-robin share of one pipelined double multiplier among NUM_REQ requesters
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake
//   mult_valid/mult_a/mult_b/mult_tag/mult_stall : registered issue port into the multiplier
//   mult_out_valid/mult_out_z/mult_out_tag : multiplier result port
//   resp_valid/resp_z : registered one-hot result routing back to requesters
//   inflight_cnt : per-requester outstanding count, tag_err : sticky bad-tag flag
module dmul_share_arbiter
    import dmul_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][63:0]      req_a,
    input  logic [NUM_REQ-1:0][63:0]      req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          mult_valid,
    output logic [63:0]                   mult_a,
    output logic [63:0]                   mult_b,
    output tag_t                          mult_tag,
    input  logic                          mult_stall,
    input  logic                          mult_out_valid,
    input  logic [63:0]                   mult_out_z,
    input  tag_t                          mult_out_tag,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [63:0]                   resp_z,
    output logic [NUM_REQ-1:0][CNT_W-1:0] inflight_cnt,
    output logic                          tag_err
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      idx;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_hit;
    logic               found;
    logic               rsp_bad;

    always_comb begin
        elig    = '0;
        rsp_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]    = req_valid[i] && (inflight_cnt[i] < CNT_W'(MAX_INFLIGHT));
            rsp_hit[i] = mult_out_valid && (mult_out_tag.req_id == REQ_ID_W'(i)) && (inflight_cnt[i] != '0);
        end
    end

    // Out-of-range ids and ids with nothing outstanding both fall out as no hit.
    assign rsp_bad   = mult_out_valid && !(|rsp_hit);
    assign req_ready = mult_stall ? '0 : grant;

    rr_pick #(.N(NUM_REQ), .W(PW)) u_pick (
        .elig  (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .found (found)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            mult_valid   <= 1'b0;
            mult_a       <= '0;
            mult_b       <= '0;
            mult_tag     <= '0;
            resp_valid   <= '0;
            resp_z       <= '0;
            inflight_cnt <= '0;
            tag_err      <= 1'b0;
        end else begin
            if (!mult_stall) begin
                mult_valid <= found;
                if (found) begin
                    mult_a          <= req_a[idx];
                    mult_b          <= req_b[idx];
                    mult_tag.req_id <= REQ_ID_W'(idx);
                    rr_ptr          <= (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++)
                inflight_cnt[i] <= inflight_cnt[i] + CNT_W'(req_ready[i]) - CNT_W'(rsp_hit[i]);
            resp_valid <= rsp_hit;
            if (|rsp_hit)
                resp_z <= mult_out_z;
            if (rsp_bad)
                tag_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmul_share_arbiter.sv
// tb_dmul_share_arbiter: directed + random checks of dmul_share_arbiter against a queue-based model
module tb_dmul_share_arbiter;
    import dmul_share_arbiter_pkg::*;

    localparam int NR   = 4;
    localparam int MAXI = 2;
    localparam int LAT  = 6;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NR-1:0]         req_valid = '0;
    logic [NR-1:0][63:0]   req_a = '0;
    logic [NR-1:0][63:0]   req_b = '0;
    logic [NR-1:0]         req_ready;
    logic                  mult_valid;
    logic [63:0]           mult_a, mult_b;
    tag_t                  mult_tag;
    logic                  mult_stall = 1'b0;
    logic                  mult_out_valid;
    logic [63:0]           mult_out_z;
    tag_t                  mult_out_tag;
    logic [NR-1:0]         resp_valid;
    logic [63:0]           resp_z;
    logic [NR-1:0][3:0]    inflight_cnt;
    logic                  tag_err;

    logic        drop  = 1'b0;
    logic        inj_v = 1'b0;
    tag_t        inj_tag = '0;
    logic [63:0] inj_z = '0;

    logic        pv [LAT];
    logic [63:0] pz [LAT];
    tag_t        pt [LAT];

    int          m_ptr;
    int          m_cnt [NR];
    logic [63:0] q [NR][$];
    logic        e_mv, e_terr;
    logic [63:0] e_a, e_b, e_rz;
    int          e_tag;
    int          last_w;
    int          glog [$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    dmul_share_arbiter #(.NUM_REQ(NR), .MAX_INFLIGHT(MAXI)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_ready      (req_ready),
        .mult_valid     (mult_valid),
        .mult_a         (mult_a),
        .mult_b         (mult_b),
        .mult_tag       (mult_tag),
        .mult_stall     (mult_stall),
        .mult_out_valid (mult_out_valid),
        .mult_out_z     (mult_out_z),
        .mult_out_tag   (mult_out_tag),
        .resp_valid     (resp_valid),
        .resp_z         (resp_z),
        .inflight_cnt   (inflight_cnt),
        .tag_err        (tag_err)
    );

    // Stub multiplier: LAT-stage in-order pipe, frozen while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) pv[k] <= 1'b0;
        end else if (!mult_stall) begin
            pv[0] <= mult_valid;
            pz[0] <= $realtobits($bitstoreal(mult_a) * $bitstoreal(mult_b));
            pt[0] <= mult_tag;
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pz[k] <= pz[k-1];
                pt[k] <= pt[k-1];
            end
        end
    end

    assign mult_out_valid = inj_v | (pv[LAT-1] & ~mult_stall & ~drop);
    assign mult_out_tag   = inj_v ? inj_tag : pt[LAT-1];
    assign mult_out_z     = inj_v ? inj_z : pz[LAT-1];

    function automatic logic [63:0] rnd_d();
        return $realtobits($itor($urandom_range(1, 999)));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ptr  = 0;
        e_mv   = 1'b0;
        e_a    = '0;
        e_b    = '0;
        e_rz   = '0;
        e_tag  = 0;
        e_terr = 1'b0;
        last_w = -1;
        for (int i = 0; i < NR; i++) begin
            m_cnt[i] = 0;
            q[i].delete();
        end
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        #1;
        chk("rst_mult_valid", 64'(mult_valid), 64'(0));
        chk("rst_mult_a", mult_a, 64'(0));
        chk("rst_mult_b", mult_b, 64'(0));
        chk("rst_mult_tag", 64'(mult_tag), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_z", resp_z, 64'(0));
        chk("rst_inflight", 64'(inflight_cnt), 64'(0));
        chk("rst_tag_err", 64'(tag_err), 64'(0));
        req_valid  = '0;
        mult_stall = 1'b0;
        inj_v      = 1'b0;
        drop       = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // One clock of the reference model: predict grant and response from the rules, then check.
    task automatic tick();
        logic [NR-1:0] er, ehit;
        logic ebad;
        int w, r;
        #1;
        er = '0;
        ehit = '0;
        ebad = 1'b0;
        w = -1;
        if (!mult_stall)
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (w < 0 && req_valid[j] && m_cnt[j] < MAXI) w = j;
            end
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        if (mult_out_valid) begin
            r = int'(mult_out_tag.req_id);
            if (r < NR && m_cnt[r] > 0) begin
                ehit[r] = 1'b1;
                e_rz = q[r].pop_front();
                m_cnt[r]--;
            end else
                ebad = 1'b1;
        end
        if (!mult_stall) begin
            e_mv = (w >= 0);
            if (w >= 0) begin
                e_a   = req_a[w];
                e_b   = req_b[w];
                e_tag = w;
                m_ptr = (w + 1) % NR;
                q[w].push_back($realtobits($bitstoreal(req_a[w]) * $bitstoreal(req_b[w])));
                m_cnt[w]++;
                glog.push_back(w);
            end
        end
        e_terr = e_terr | ebad;
        last_w = w;
        @(posedge clock);
        #1;
        chk("mult_valid", 64'(mult_valid), 64'(e_mv));
        chk("mult_a", mult_a, e_a);
        chk("mult_b", mult_b, e_b);
        chk("mult_tag", 64'(mult_tag.req_id), 64'(e_tag));
        chk("resp_valid", 64'(resp_valid), 64'(ehit));
        chk("resp_z", resp_z, e_rz);
        for (int i = 0; i < NR; i++) chk("inflight_cnt", 64'(inflight_cnt[i]), 64'(m_cnt[i]));
        chk("tag_err", 64'(tag_err), 64'(e_terr));
    endtask

    initial begin
        int  acc;
        logic seen;
        logic [63:0] a1;
        model_clear();

        // Single requester: 2.0 * 3.0 routed back to req0.
        do_reset();
        req_valid = 4'b0001;
        req_a[0]  = 64'h4000000000000000;
        req_b[0]  = 64'h4008000000000000;
        tick();
        chk("t1_tag", 64'(mult_tag.req_id), 64'(0));
        chk("t1_cnt_up", 64'(inflight_cnt[0]), 64'(1));
        req_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = (resp_valid != '0);
        end
        chk("t1_resp_seen", 64'(seen), 64'(1));
        chk("t1_resp_valid", 64'(resp_valid), 64'(4'b0001));
        chk("t1_resp_z", resp_z, 64'h4018000000000000);
        chk("t1_cnt_down", 64'(inflight_cnt[0]), 64'(0));

        // All four requesters contending: strict rotation.
        do_reset();
        glog.delete();
        for (int i = 0; i < NR; i++) begin
            req_a[i] = rnd_d();
            req_b[i] = rnd_d();
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (last_w >= 0) begin
                req_a[last_w] = rnd_d();
                req_b[last_w] = rnd_d();
            end
        end
        chk("t2_grant_n", 64'(glog.size()), 64'(8));
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("t2_grant", 64'(glog[k]), 64'(k % NR));
        req_valid = '0;
        repeat (14) tick();
        chk("t2_drained", 64'(inflight_cnt), 64'(0));

        // Stall holds everything; req1 goes on the first unstalled cycle.
        do_reset();
        req_valid = 4'b0001;
        req_a[0] = rnd_d();
        req_b[0] = rnd_d();
        tick();
        a1 = rnd_d();
        req_valid  = 4'b0010;
        req_a[1]   = a1;
        req_b[1]   = rnd_d();
        mult_stall = 1'b1;
        repeat (3) begin
            tick();
            chk("t3_ready_low", 64'(req_ready), 64'(0));
        end
        mult_stall = 1'b0;
        tick();
        chk("t3_tag", 64'(mult_tag.req_id), 64'(1));
        chk("t3_a", mult_a, a1);
        req_valid = '0;
        repeat (12) tick();

        // In-flight cap with results withheld, then one result frees a slot.
        do_reset();
        drop = 1'b1;
        req_valid = 4'b0100;
        req_a[2] = rnd_d();
        req_b[2] = rnd_d();
        acc = 0;
        repeat (6) begin
            tick();
            if (last_w == 2) begin
                acc++;
                req_a[2] = rnd_d();
                req_b[2] = rnd_d();
            end
        end
        chk("t4_capped", 64'(acc), 64'(MAXI));
        chk("t4_ready_low", 64'(req_ready), 64'(0));
        inj_tag.req_id = 3'd2;
        inj_z = q[2][0];
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        repeat (3) begin
            tick();
            if (last_w == 2) acc++;
        end
        chk("t4_one_more", 64'(acc), 64'(MAXI + 1));

        // Accept and response for req3 in the same cycle keeps the count.
        do_reset();
        req_valid = 4'b1000;
        req_a[3] = rnd_d();
        req_b[3] = rnd_d();
        tick();
        req_valid = '0;
        for (int k = 0; k < 20 && !mult_out_valid; k++) tick();
        chk("t5_out_seen", 64'(mult_out_valid), 64'(1));
        req_valid = 4'b1000;
        req_a[3] = rnd_d();
        req_b[3] = rnd_d();
        tick();
        chk("t5_cnt_same", 64'(inflight_cnt[3]), 64'(1));
        chk("t5_resp", 64'(resp_valid), 64'(4'b1000));
        req_valid = '0;
        repeat (10) tick();

        // Bad tags: nothing outstanding, then out of range; tag_err sticks.
        do_reset();
        inj_tag.req_id = 3'd0;
        inj_z = rnd_d();
        inj_v = 1'b1;
        tick();
        chk("t6_err_idle", 64'(tag_err), 64'(1));
        chk("t6_no_resp", 64'(resp_valid), 64'(0));
        inj_tag.req_id = 3'd5;
        tick();
        inj_v = 1'b0;
        repeat (3) tick();
        chk("t6_sticky", 64'(tag_err), 64'(1));

        // Random traffic with stalls and withdrawals, reset asynchronously mid-burst.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] || last_w == i) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[i] = rnd_d();
                    req_b[i] = rnd_d();
                end else if ($urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
            mult_stall = ($urandom_range(0, 4) == 0);
            tick();
            if (c == 200) do_reset();
        end
        req_valid  = '0;
        mult_stall = 1'b0;
        repeat (14) tick();
        chk("rand_drained", 64'(inflight_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
